curl_absorb_ctrl: RTL and testbench

//  Parametrised request controller that sits between the host data path and one curl transform core.

---
 rtl/curl_ctrl_pkg.sv | 14 +
 rtl/curl_absorb_ctrl_if.sv | 24 ++
 rtl/curl_absorb_ctrl_watchdog.sv | 28 ++
 rtl/curl_absorb_ctrl.sv | 115 +++++++++++
 tb/tb_curl_absorb_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/curl_ctrl_pkg.sv
// Shared constants and state encoding for the curl absorb controller.
// HASH_LENGTH default matches the transform core parameter set.
package curl_ctrl_pkg;
  localparam int CURL_HASH_LENGTH = 486;
  localparam int CURL_OUT_LENGTH = 2 * CURL_HASH_LENGTH;
  localparam int CURL_MAX_PARTS = 16;
  localparam int CURL_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    OUT
  } curl_ctrl_state_t;
endpackage

// File: rtl/curl_absorb_ctrl_if.sv
// Host-side streams: message parts in, final core state out.
// Both directions use valid/ready handshakes.
interface curl_absorb_ctrl_if #(
  parameter int HASH_LENGTH = 486,
  parameter int OUT_LENGTH = 972
);
  logic [HASH_LENGTH-1:0] s_hash;
  logic                   s_last;
  logic                   s_valid;
  logic                   s_ready;
  logic [OUT_LENGTH-1:0]  m_hash;
  logic                   m_valid;
  logic                   m_ready;

  modport master (
    output s_hash, s_last, s_valid, m_ready,
    input  s_ready, m_hash, m_valid
  );

  modport slave (
    input  s_hash, s_last, s_valid, m_ready,
    output s_ready, m_hash, m_valid
  );
endinterface

// File: rtl/curl_absorb_ctrl_watchdog.sv
// Saturating cycle counter; the cycle of clear counts as cycle one.
// expire marks the last cycle the core may finish in.
module curl_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LIM = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= TW'(1);
    end else if (en && cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == LIM);
endmodule

// File: rtl/curl_absorb_ctrl.sv
// Feeds a message part-by-part into one curl core and returns
// the final state; watchdog aborts a stuck transform.
module curl_absorb_ctrl
  import curl_ctrl_pkg::*;
#(
  parameter int HASH_LENGTH = CURL_HASH_LENGTH,
  parameter int OUT_LENGTH = CURL_OUT_LENGTH,
  parameter int MAX_PARTS = CURL_MAX_PARTS,
  parameter int TIMEOUT_CYCLES = CURL_TIMEOUT_CYCLES,
  localparam int CW = (MAX_PARTS > 1) ? $clog2(MAX_PARTS) : 1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  curl_absorb_ctrl_if.slave      host,
  output logic [HASH_LENGTH-1:0] core_in_hash,
  output logic                   core_load,
  output logic                   core_first,
  input  logic                   core_finish,
  input  logic [OUT_LENGTH-1:0]  core_out_hash,
  output logic [CW-1:0]          part_cnt,
  output logic                   err_timeout,
  output logic                   err_len
);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PARTS - 1);

  curl_ctrl_state_t      state;
  logic                  s_ready_q;
  logic                  m_valid_q;
  logic [OUT_LENGTH-1:0] m_hash_q;
  logic                  first_flag;
  logic                  last_q;
  logic                  accept;
  logic                  expire;
  logic                  at_cap;

  assign accept = (state == IDLE) && host.s_valid && s_ready_q;
  assign at_cap = (part_cnt == LAST_IDX);

  assign host.s_ready = s_ready_q;
  assign host.m_valid = m_valid_q;
  assign host.m_hash  = m_hash_q;

  curl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst_n (arst_n),
    .clear (accept),
    .en    (state == WAIT),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state        <= IDLE;
      s_ready_q    <= 1'b1;
      m_valid_q    <= 1'b0;
      m_hash_q     <= '0;
      core_in_hash <= '0;
      core_load    <= 1'b0;
      core_first   <= 1'b1;
      first_flag   <= 1'b1;
      last_q       <= 1'b0;
      part_cnt     <= '0;
      err_timeout  <= 1'b0;
      err_len      <= 1'b0;
    end else begin
      core_load <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            core_in_hash <= host.s_hash;
            last_q       <= host.s_last || at_cap;
            core_load    <= 1'b1;
            core_first   <= first_flag;
            s_ready_q    <= 1'b0;
            state        <= WAIT;
            if (at_cap && !host.s_last) err_len <= 1'b1;
          end
        end
        WAIT: begin
          // finish beats the watchdog in its expiry cycle
          if (core_finish) begin
            if (last_q) begin
              m_hash_q  <= core_out_hash;
              m_valid_q <= 1'b1;
              state     <= OUT;
            end else begin
              part_cnt   <= part_cnt + 1'b1;
              first_flag <= 1'b0;
              s_ready_q  <= 1'b1;
              state      <= IDLE;
            end
          end else if (expire) begin
            err_timeout <= 1'b1;
            part_cnt    <= '0;
            first_flag  <= 1'b1;
            s_ready_q   <= 1'b1;
            state       <= IDLE;
          end
        end
        OUT: begin
          if (host.m_ready) begin
            m_valid_q  <= 1'b0;
            part_cnt   <= '0;
            first_flag <= 1'b1;
            s_ready_q  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_curl_absorb_ctrl.sv
// Directed bench for curl_absorb_ctrl with MAX_PARTS=4 and a
// short watchdog; timing is counted from the part-accept edge.
module tb_curl_absorb_ctrl;
  localparam int HL = 486;
  localparam int OL = 972;
  localparam int MP = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [HL-1:0] core_in_hash;
  logic          core_load;
  logic          core_first;
  logic          core_finish = 1'b0;
  logic [OL-1:0] core_out_hash = '0;
  logic [1:0]    part_cnt;
  logic          err_timeout;
  logic          err_len;

  curl_absorb_ctrl_if #(.HASH_LENGTH(HL), .OUT_LENGTH(OL)) bus ();

  curl_absorb_ctrl #(
    .HASH_LENGTH(HL),
    .OUT_LENGTH(OL),
    .MAX_PARTS(MP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .host         (bus.slave),
    .core_in_hash (core_in_hash),
    .core_load    (core_load),
    .core_first   (core_first),
    .core_finish  (core_finish),
    .core_out_hash(core_out_hash),
    .part_cnt     (part_cnt),
    .err_timeout  (err_timeout),
    .err_len      (err_len)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [1023:0] h;
  logic [1023:0] o;

  function automatic logic [1023:0] pat(input logic [31:0] s,
                                        input int w);
    logic [1023:0] r;
    logic [1023:0] m;
    r = {32{s}};
    m = (1024'b1 << w) - 1'b1;
    return r & m;
  endfunction

  task automatic chk(input string tag, input logic [1023:0] obs,
                     input logic [1023:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h required 'h%0h",
             tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1023:0] hv, input logic last);
    bus.s_hash = hv[HL-1:0];
    bus.s_last = last;
    bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
  endtask

  task automatic fin(input logic [1023:0] ov);
    core_out_hash = ov[OL-1:0];
    core_finish = 1'b1;
    step();
    core_finish = 1'b0;
  endtask

  task automatic drain();
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no end required finish");
    $fatal(1);
  end

  initial begin
    bus.s_hash = '0;
    bus.s_last = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    step();
    step();
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_first", core_first, 1);
    chk("rst_load", core_load, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_cnt", part_cnt, 0);
    chk("rst_errs", {err_timeout, err_len}, 0);
    arst_n = 1'b1;
    step();

    // stray finish in IDLE
    fin(pat(32'hdead_beef, OL));
    chk("idle_fin_ready", bus.s_ready, 1);
    chk("idle_fin_mv", bus.m_valid, 0);
    chk("idle_fin_cnt", part_cnt, 0);

    // 1: single part, finish 5 cycles after load
    h = pat(32'h1111_0001, HL);
    send(h, 1'b1);
    chk("t1_load", core_load, 1);
    chk("t1_first", core_first, 1);
    chk("t1_cnt", part_cnt, 0);
    chk("t1_in", core_in_hash, h);
    chk("t1_s_ready", bus.s_ready, 0);
    step();
    chk("t1_load_pulse", core_load, 0);
    repeat (3) step();
    chk("t1_mv_early", bus.m_valid, 0);
    step();
    o = pat(32'hc0de_0001, OL);
    fin(o);
    chk("t1_mv", bus.m_valid, 1);
    chk("t1_mh", bus.m_hash, o);
    drain();
    chk("t1_mv_clr", bus.m_valid, 0);
    chk("t1_ready", bus.s_ready, 1);

    // 2: three parts
    for (int p = 0; p < 3; p++) begin
      h = pat(32'h2000_0000 + p, HL);
      send(h, p == 2);
      chk("t2_first", core_first, p == 0);
      chk("t2_cnt", part_cnt, p);
      chk("t2_in", core_in_hash, h);
      repeat (3) step();
      o = pat(32'h2222_0000 + p, OL);
      fin(o);
      if (p < 2) begin
        chk("t2_mv_mid", bus.m_valid, 0);
        chk("t2_ready_mid", bus.s_ready, 1);
      end else begin
        chk("t2_mv", bus.m_valid, 1);
        chk("t2_mh", bus.m_hash, o);
      end
    end
    drain();

    // 3: backpressure in OUT
    h = pat(32'h3333_0003, HL);
    send(h, 1'b1);
    chk("t3_first", core_first, 1);
    chk("t3_cnt", part_cnt, 0);
    repeat (2) step();
    o = pat(32'h3c3c_a5a5, OL);
    fin(o);
    bus.s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t3_mv_hold", bus.m_valid, 1);
      chk("t3_mh_hold", bus.m_hash, o);
      chk("t3_s_ready", bus.s_ready, 0);
      chk("t3_no_load", core_load, 0);
      step();
    end
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b0;
    chk("t3_mv_clr", bus.m_valid, 0);
    chk("t3_idle", bus.s_ready, 1);
    chk("t3_no_load2", core_load, 0);

    // 4b: finish in the watchdog expiry cycle
    h = pat(32'h4b4b_0001, HL);
    send(h, 1'b1);
    repeat (TO - 2) step();
    chk("t4b_err_pre", err_timeout, 0);
    o = pat(32'h4b4b_f00d, OL);
    fin(o);
    chk("t4b_mv", bus.m_valid, 1);
    chk("t4b_mh", bus.m_hash, o);
    chk("t4b_err", err_timeout, 0);
    drain();

    // 4: timeout on second part
    send(pat(32'h4000_0000, HL), 1'b0);
    repeat (2) step();
    fin(pat(32'h4000_1111, OL));
    chk("t4_ready", bus.s_ready, 1);
    chk("t4_cnt1", part_cnt, 1);
    send(pat(32'h4000_0001, HL), 1'b0);
    chk("t4_first0", core_first, 0);
    repeat (TO - 2) step();
    chk("t4_err_pre", err_timeout, 0);
    chk("t4_busy", bus.s_ready, 0);
    step();
    chk("t4_err", err_timeout, 1);
    chk("t4_ready2", bus.s_ready, 1);
    chk("t4_mv", bus.m_valid, 0);
    chk("t4_cnt0", part_cnt, 0);
    h = pat(32'h4444_0002, HL);
    send(h, 1'b1);
    chk("t4_first1", core_first, 1);
    chk("t4_in", core_in_hash, h);
    repeat (2) step();
    o = pat(32'h4444_9999, OL);
    fin(o);
    chk("t4_mv2", bus.m_valid, 1);
    chk("t4_mh2", bus.m_hash, o);
    drain();

    // 5: no s_last, part 3 forced last
    for (int p = 0; p < 4; p++) begin
      send(pat(32'h5000_0000 + p, HL), 1'b0);
      chk("t5_cnt", part_cnt, p);
      chk("t5_first", core_first, p == 0);
      chk("t5_err_len", err_len, p == 3);
      repeat (2) step();
      o = pat(32'h5555_0000 + p, OL);
      fin(o);
      chk("t5_mv", bus.m_valid, p == 3);
    end
    chk("t5_mh", bus.m_hash, o);
    drain();
    send(pat(32'h5000_0004, HL), 1'b0);
    chk("t5_p4_first", core_first, 1);
    chk("t5_p4_cnt", part_cnt, 0);
    chk("t5_len_sticky", err_len, 1);
    repeat (2) step();
    fin(pat(32'h5555_0004, OL));
    send(pat(32'h5000_0005, HL), 1'b0);
    chk("t5_p5_first", core_first, 0);
    chk("t5_p5_cnt", part_cnt, 1);
    repeat (2) step();
    fin(pat(32'h5555_0005, OL));

    // 6: reset during WAIT of part 2
    send(pat(32'h6000_0002, HL), 1'b0);
    chk("t6_cnt2", part_cnt, 2);
    step();
    arst_n = 1'b0;
    step();
    arst_n = 1'b1;
    chk("t6_s_ready", bus.s_ready, 1);
    chk("t6_first", core_first, 1);
    chk("t6_load", core_load, 0);
    chk("t6_mv", bus.m_valid, 0);
    chk("t6_cnt", part_cnt, 0);
    chk("t6_errs", {err_timeout, err_len}, 0);
    chk("t6_mh", bus.m_hash, 0);
    chk("t6_in", core_in_hash, 0);
    h = pat(32'h6666_0001, HL);
    send(h, 1'b1);
    chk("t6_first2", core_first, 1);
    chk("t6_in2", core_in_hash, h);
    repeat (4) step();
    o = pat(32'h6666_abcd, OL);
    fin(o);
    chk("t6_mv2", bus.m_valid, 1);
    chk("t6_mh2", bus.m_hash, o);
    drain();
    chk("t6_done", bus.m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
